// File: rtl/spi_stream_arbiter.sv
// -----------------------------------------------------------------------------
// spi_stream_arbiter
//
// Round-robin arbiter that merges NUM_REQ val/rdy requester streams into the
// single response stream feeding the SPI adapter's push interface. Each
// accepted payload is tagged with its source index and held in a one-entry
// output buffer. A per-requester enable mask removes requesters from
// arbitration without disturbing data already buffered.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset (0 = reset)
//   en_mask    per-requester arbitration enable
//   recv_val   per-requester valid
//   recv_rdy   per-requester ready, one-hot or zero
//   recv_msg   packed payloads, requester i at [i*DATA_W +: DATA_W]
//   send_val   output buffer holds a message
//   send_rdy   downstream ready
//   send_msg   {src_idx, payload}, source index in the MSBs
//   grant_idx  index of the most recently accepted requester (debug)
// -----------------------------------------------------------------------------
module spi_stream_arbiter #(
   parameter int  NUM_REQ = 4,
   parameter int  DATA_W  = 16,
   localparam int ADDR_W  = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        en_mask,
   input  logic [NUM_REQ-1:0]        recv_val,
   output logic [NUM_REQ-1:0]        recv_rdy,
   input  logic [NUM_REQ*DATA_W-1:0] recv_msg,
   output logic                      send_val,
   input  logic                      send_rdy,
   output logic [ADDR_W+DATA_W-1:0]  send_msg,
   output logic [ADDR_W-1:0]         grant_idx
);

   logic [NUM_REQ-1:0]       req_s;
   logic [ADDR_W-1:0]        win_s;
   logic [ADDR_W-1:0]        cand_s;
   int                       sum_s;
   logic                     free_s;
   logic                     accept_s;
   logic [DATA_W-1:0]        win_data_s;

   logic                     buf_full_r;
   logic [ADDR_W+DATA_W-1:0] buf_msg_r;
   logic [ADDR_W-1:0]        ptr_r;
   logic [ADDR_W-1:0]        grant_r;

   // Round-robin winner search starting at ptr_r.
   // Walking offsets from the far end back to zero lets the offset closest to
   // ptr_r overwrite later candidates, so it wins without a priority flag.
   always_comb begin
      req_s  = recv_val & en_mask;
      win_s  = '0;
      cand_s = '0;
      sum_s  = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum_s  = int'(ptr_r) + k;
         cand_s = (sum_s >= NUM_REQ) ? ADDR_W'(sum_s - NUM_REQ) : ADDR_W'(sum_s);
         win_s  = req_s[cand_s] ? cand_s : win_s;
      end
   end

   // Handshake decision and payload selection for the current winner.
   // The buffer is free when empty or when it drains this same cycle.
   always_comb begin
      free_s     = !buf_full_r || send_rdy;
      accept_s   = free_s && (req_s != '0) && reset;
      win_data_s = recv_msg[int'(win_s) * DATA_W +: DATA_W];
      if (accept_s) begin
         recv_rdy = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
      end else begin
         recv_rdy = '0;
      end
   end

   // Output buffer, round-robin pointer and debug grant registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         buf_full_r <= 1'b0;
         buf_msg_r  <= '0;
         ptr_r      <= '0;
         grant_r    <= '0;
      end else if (accept_s) begin
         // Accept wins over drain: a simultaneous drain just refills the buffer.
         buf_full_r <= 1'b1;
         buf_msg_r  <= {win_s, win_data_s};
         ptr_r      <= (win_s == ADDR_W'(NUM_REQ - 1)) ? '0 : win_s + ADDR_W'(1);
         grant_r    <= win_s;
      end else if (buf_full_r && send_rdy) begin
         buf_full_r <= 1'b0;
      end else begin
         buf_full_r <= buf_full_r;
      end
   end

   assign send_val  = buf_full_r;
   assign send_msg  = buf_msg_r;
   assign grant_idx = grant_r;

endmodule

// File: tb/tb_spi_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_stream_arbiter
//
// Self-checking bench for spi_stream_arbiter (NUM_REQ = 4, DATA_W = 16).
// A cycle-level reference model (buffer contents, pointer as an integer,
// winner found with modulo search) predicts recv_rdy before each edge and the
// registered outputs after it. Directed scenario tasks are followed by a
// randomized run with sporadic resets.
// -----------------------------------------------------------------------------
module tb_spi_stream_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  en_mask;
   logic [3:0]  recv_val;
   logic [3:0]  recv_rdy;
   logic [63:0] recv_msg;
   logic        send_val;
   logic        send_rdy;
   logic [17:0] send_msg;
   logic [1:0]  grant_idx;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   bit          m_full;
   logic [17:0] m_msg;
   int          m_ptr;
   logic [1:0]  m_grant;

   spi_stream_arbiter #(.NUM_REQ(4), .DATA_W(16)) dut (
      .clk(clk), .reset(reset), .en_mask(en_mask), .recv_val(recv_val),
      .recv_rdy(recv_rdy), .recv_msg(recv_msg), .send_val(send_val),
      .send_rdy(send_rdy), .send_msg(send_msg), .grant_idx(grant_idx)
   );

   always #5 clk = ~clk;

   // winner index for the current inputs, -1 if no accept happens
   function automatic int model_win();
      logic [3:0] req;
      req = recv_val & en_mask;
      if (!reset) return -1;
      if (m_full && !send_rdy) return -1;
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (m_ptr + k) % 4;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_rdy();
      int w;
      w = model_win();
      if (w < 0) return 4'b0000;
      return 4'b0001 << w;
   endfunction

   // advance one clock edge and update the model from the pre-edge inputs
   task automatic cycle();
      int w;
      w = model_win();
      @(posedge clk);
      if (!reset) begin
         m_full = 1'b0; m_msg = 18'd0; m_ptr = 0; m_grant = 2'd0;
      end else if (w >= 0) begin
         m_msg   = {w[1:0], recv_msg[w*16 +: 16]};
         m_full  = 1'b1;
         m_ptr   = (w + 1) % 4;
         m_grant = w[1:0];
      end else if (m_full && send_rdy) begin
         m_full = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; recv_val = 4'b0000; en_mask = 4'b1111; send_rdy = 1'b1;
      cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; recv_val = 4'b1111; en_mask = 4'b1111; send_rdy = 1'b1;
      recv_msg = {$urandom, $urandom};
      #1;
      n_vec++;
      if (recv_rdy !== 4'b0000) begin
         n_bad++; $display("FAIL rdy_in_reset: got %b expected 0000", recv_rdy);
      end
      cycle(); cycle();
      reset = 1'b1; recv_val = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_vec++;
         if (recv_rdy !== 4'b0000) begin
            n_bad++; $display("FAIL reset_rdy: got %b expected 0000", recv_rdy);
         end
         cycle();
         n_vec++;
         if (send_val !== 1'b0 || grant_idx !== 2'd0 || send_msg !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_state: got val=%b grant=%0d msg=%h expected 0 0 0",
                     send_val, grant_idx, send_msg);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      recv_msg = {$urandom, $urandom};
      recv_msg[32 +: 16] = 16'hBEEF;
      recv_val = 4'b0100;
      #1;
      n_vec++;
      if (recv_rdy !== 4'b0100) begin
         n_bad++; $display("FAIL single_rdy: got %b expected 0100", recv_rdy);
      end
      cycle();
      recv_val = 4'b0000;
      n_vec++;
      if (send_val !== 1'b1 || send_msg !== {2'd2, 16'hBEEF}) begin
         n_bad++;
         $display("FAIL single_out: got val=%b msg=%h expected 1 %h",
                  send_val, send_msg, {2'd2, 16'hBEEF});
      end
      cycle();
      n_vec++;
      if (send_val !== 1'b0) begin
         n_bad++; $display("FAIL single_drain: got val=%b expected 0", send_val);
      end
   endtask

   // all four valid, send_rdy=1: expect the given grant order
   task automatic run_sequence(input string name, input logic [3:0] mask,
                               input int e0, input int e1, input int e2,
                               input int e3, input int e4, input int e5);
      int exp_q[6];
      logic [15:0] d;
      exp_q = '{e0, e1, e2, e3, e4, e5};
      do_reset();
      en_mask = mask; recv_val = 4'b1111; send_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         recv_msg = {$urandom, $urandom};
         d = recv_msg[exp_q[i]*16 +: 16];
         #1;
         n_vec++;
         if (recv_rdy !== (4'b0001 << exp_q[i])) begin
            n_bad++;
            $display("FAIL %s_rdy[%0d]: got %b expected grant %0d", name, i, recv_rdy, exp_q[i]);
         end
         cycle();
         n_vec++;
         if (send_val !== 1'b1 || grant_idx !== exp_q[i][1:0] ||
             send_msg !== {exp_q[i][1:0], d}) begin
            n_bad++;
            $display("FAIL %s_out[%0d]: got val=%b grant=%0d msg=%h expected 1 %0d %h",
                     name, i, send_val, grant_idx, send_msg, exp_q[i], {exp_q[i][1:0], d});
         end
      end
      recv_val = 4'b0000; en_mask = 4'b1111;
   endtask

   task automatic test_round_robin();
      run_sequence("rr", 4'b1111, 0, 1, 2, 3, 0, 1);
   endtask

   task automatic test_mask();
      run_sequence("mask", 4'b1011, 0, 1, 3, 0, 1, 3);
   endtask

   task automatic test_backpressure();
      do_reset();
      recv_msg = {$urandom, $urandom};
      recv_msg[16 +: 16] = 16'h0011;
      recv_val = 4'b0010;
      #1;
      n_vec++;
      if (recv_rdy !== 4'b0010) begin
         n_bad++; $display("FAIL bp_load_rdy: got %b expected 0010", recv_rdy);
      end
      cycle();
      send_rdy = 1'b0; recv_val = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         recv_msg = {$urandom, $urandom};
         #1;
         n_vec++;
         if (recv_rdy !== 4'b0000) begin
            n_bad++; $display("FAIL bp_hold_rdy[%0d]: got %b expected 0000", i, recv_rdy);
         end
         cycle();
         n_vec++;
         if (send_val !== 1'b1 || send_msg !== {2'd1, 16'h0011}) begin
            n_bad++;
            $display("FAIL bp_hold_msg[%0d]: got val=%b msg=%h expected 1 %h",
                     i, send_val, send_msg, {2'd1, 16'h0011});
         end
      end
      send_rdy = 1'b1;
      recv_msg = {$urandom, $urandom};
      #1;
      n_vec++;
      if (recv_rdy !== 4'b1000) begin
         n_bad++; $display("FAIL bp_release_rdy: got %b expected 1000", recv_rdy);
      end
      cycle();
      n_vec++;
      if (send_val !== 1'b1 || send_msg !== {2'd3, m_msg[15:0]} || m_msg[17:16] !== 2'd3) begin
         n_bad++;
         $display("FAIL bp_release_msg: got val=%b msg=%h expected tag 3 msg %h",
                  send_val, send_msg, m_msg);
      end
      recv_val = 4'b0000;
      cycle();
   endtask

   task automatic test_reset_mid();
      logic [15:0] d1;
      do_reset();
      send_rdy = 1'b0; recv_val = 4'b1000;
      recv_msg = {$urandom, $urandom};
      recv_msg[48 +: 16] = 16'hCAFE;
      cycle();
      reset = 1'b0; recv_val = 4'b0110;
      #1;
      n_vec++;
      if (recv_rdy !== 4'b0000) begin
         n_bad++; $display("FAIL mid_rst_rdy: got %b expected 0000", recv_rdy);
      end
      cycle();
      n_vec++;
      if (send_val !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst_val: got %b expected 0", send_val);
      end
      reset = 1'b1; send_rdy = 1'b1;
      d1 = recv_msg[16 +: 16];
      #1;
      n_vec++;
      if (recv_rdy !== 4'b0010) begin
         n_bad++; $display("FAIL mid_rst_first_rdy: got %b expected 0010", recv_rdy);
      end
      cycle();
      n_vec++;
      if (send_val !== 1'b1 || send_msg !== {2'd1, d1}) begin
         n_bad++;
         $display("FAIL mid_rst_first_msg: got val=%b msg=%h expected 1 %h",
                  send_val, send_msg, {2'd1, d1});
      end
      recv_val = 4'b0000;
   endtask

   task automatic test_random();
      logic [3:0] exp_rdy;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset    = ($urandom_range(0, 39) != 0);
         recv_val = 4'($urandom);
         en_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
         send_rdy = ($urandom_range(0, 2) != 0);
         recv_msg = {$urandom, $urandom};
         #1;
         exp_rdy = model_rdy();
         n_vec++;
         if (recv_rdy !== exp_rdy) begin
            n_bad++; $display("FAIL rand_rdy[%0d]: got %b expected %b", i, recv_rdy, exp_rdy);
         end
         cycle();
         n_vec++;
         if (send_val !== m_full || grant_idx !== m_grant) begin
            n_bad++;
            $display("FAIL rand_state[%0d]: got val=%b grant=%0d expected %b %0d",
                     i, send_val, grant_idx, m_full, m_grant);
         end
         if (m_full) begin
            n_vec++;
            if (send_msg !== m_msg) begin
               n_bad++; $display("FAIL rand_msg[%0d]: got %h expected %h", i, send_msg, m_msg);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0; en_mask = 4'b1111; recv_val = 4'b0000;
      recv_msg = 64'd0; send_rdy = 1'b1;
      m_full = 1'b0; m_msg = 18'd0; m_ptr = 0; m_grant = 2'd0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_mask();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
